// File: rtl/link_power_sequencer.sv
// Purpose: sequences CHANNELS supply rails up in ascending order (ramp, power-good qualify, bounded retry) and down in reverse order.
// Latency: all outputs registered; the first rail's SupplyOn rises the cycle after Enable is sampled high in IDLE.
// Backpressure: none; Enable is a level request, and no handshake is applied to PowerGood or the rail outputs.
//
// Ports:
//   i_Clock100Mhz  single clock, rising edge
//   i_Reset        synchronous active-high reset, priority over everything
//   i_Enable       1 = sequence up and hold, 0 = sequence down
//   i_ChannelMask  rails that participate; latched when leaving IDLE
//   i_PowerGood    per-rail comparator status, synchronous to i_Clock100Mhz
//   o_SupplyOn     per-rail supply enable
//   o_Fault        sticky per-rail fault flag
//   o_Ready        sequence complete with at least one rail up
//   o_Busy         sequencing in progress (any state other than IDLE and UP)
module link_power_sequencer #(
   parameter int CHANNELS      = 4,
   parameter int RAMP_CYCLES   = 1000,
   parameter int SETTLE_CYCLES = 100,
   parameter int RETRY_LIMIT   = 3,
   parameter int COUNT_WIDTH   = 16
) (
   input  logic                i_Clock100Mhz,
   input  logic                i_Reset,
   input  logic                i_Enable,
   input  logic [CHANNELS-1:0] i_ChannelMask,
   input  logic [CHANNELS-1:0] i_PowerGood,
   output logic [CHANNELS-1:0] o_SupplyOn,
   output logic [CHANNELS-1:0] o_Fault,
   output logic                o_Ready,
   output logic                o_Busy
);

   localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int RTY_W = $clog2(RETRY_LIMIT + 2);

   localparam logic [COUNT_WIDTH-1:0] RAMP_LAST   = COUNT_WIDTH'(RAMP_CYCLES - 1);
   localparam logic [COUNT_WIDTH-1:0] SETTLE_LAST = COUNT_WIDTH'(SETTLE_CYCLES - 1);
   localparam logic [COUNT_WIDTH-1:0] SETTLE_GOOD = COUNT_WIDTH'(SETTLE_CYCLES);
   localparam logic [RTY_W-1:0]       RETRY_MAX   = RTY_W'(RETRY_LIMIT);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RAMP,
      ST_SETTLE,
      ST_COOL,
      ST_UP,
      ST_DOWN
   } state_t;

   state_t               r_state;
   logic [IDX_W-1:0]     r_idx;
   logic [COUNT_WIDTH-1:0] r_cnt;    // ramp, settle-timeout, cool and down-step counter
   logic [COUNT_WIDTH-1:0] r_good;   // consecutive power-good cycles in SETTLE
   logic [RTY_W-1:0]     r_retry;
   logic [CHANNELS-1:0]  r_mask;
   logic [CHANNELS-1:0]  r_supply;
   logic [CHANNELS-1:0]  r_fault;
   logic                 r_ready;
   logic                 r_busy;

   state_t               w_state_nxt;
   logic [IDX_W-1:0]     w_idx_nxt;
   logic [COUNT_WIDTH-1:0] w_cnt_nxt;
   logic [COUNT_WIDTH-1:0] w_good_nxt;
   logic [RTY_W-1:0]     w_retry_nxt;
   logic [CHANNELS-1:0]  w_mask_nxt;
   logic [CHANNELS-1:0]  w_supply_nxt;
   logic [CHANNELS-1:0]  w_fault_nxt;
   logic                 w_ready_nxt;
   logic                 w_busy_nxt;

   logic [IDX_W-1:0]     w_first_idx;
   logic [IDX_W-1:0]     w_next_idx;
   logic                 w_next_found;
   logic [CHANNELS-1:0]  w_pre_supply;
   logic [IDX_W-1:0]     w_high_idx;
   logic                 w_any_on;
   logic [COUNT_WIDTH-1:0] w_good_run;
   logic                 w_advance;
   logic                 w_go_down;

   // Channel search helpers: lowest requested rail, next masked rail above
   // idx, and highest rail still on.  In UP the rails that just lost
   // power-good are removed first so a simultaneous Enable drop steps down
   // from the correct rail.
   always_comb begin
      w_first_idx  = '0;
      w_next_idx   = '0;
      w_next_found = 1'b0;
      w_high_idx   = '0;
      w_pre_supply = (r_state == ST_UP) ? (r_supply & i_PowerGood) : r_supply;
      w_any_on     = |w_pre_supply;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (i_ChannelMask[i]) begin
            w_first_idx = IDX_W'(i);
         end
         if (r_mask[i] && (IDX_W'(i) > r_idx)) begin
            w_next_idx   = IDX_W'(i);
            w_next_found = 1'b1;
         end
      end
      for (int i = 0; i < CHANNELS; i++) begin
         if (w_pre_supply[i]) begin
            w_high_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_idx_nxt    = r_idx;
      w_cnt_nxt    = r_cnt;
      w_good_nxt   = r_good;
      w_retry_nxt  = r_retry;
      w_mask_nxt   = r_mask;
      w_supply_nxt = r_supply;
      w_fault_nxt  = r_fault;
      w_advance    = 1'b0;
      w_go_down    = 1'b0;
      w_good_run   = i_PowerGood[r_idx] ? (r_good + 1'b1) : '0;

      case (r_state)
         ST_IDLE: begin
            if (i_Enable && (|i_ChannelMask)) begin
               w_mask_nxt                = i_ChannelMask;
               w_fault_nxt               = '0;
               w_idx_nxt                 = w_first_idx;
               w_cnt_nxt                 = '0;
               w_good_nxt                = '0;
               w_retry_nxt               = '0;
               w_supply_nxt[w_first_idx] = 1'b1;
               w_state_nxt               = ST_RAMP;
            end
         end
         ST_RAMP: begin
            if (!i_Enable) begin
               w_go_down = 1'b1;
            end else if (r_cnt == RAMP_LAST) begin
               w_cnt_nxt   = '0;
               w_good_nxt  = '0;
               w_state_nxt = ST_SETTLE;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_SETTLE: begin
            // Qualification wins over a timeout landing on the same cycle.
            if (!i_Enable) begin
               w_go_down = 1'b1;
            end else if (w_good_run == SETTLE_GOOD) begin
               w_advance = 1'b1;
            end else if (r_cnt == RAMP_LAST) begin
               w_supply_nxt[r_idx] = 1'b0;
               if (r_retry < RETRY_MAX) begin
                  w_retry_nxt = r_retry + 1'b1;
                  w_cnt_nxt   = '0;
                  w_state_nxt = ST_COOL;
               end else begin
                  w_fault_nxt[r_idx] = 1'b1;
                  w_advance          = 1'b1;
               end
            end else begin
               w_cnt_nxt  = r_cnt + 1'b1;
               w_good_nxt = w_good_run;
            end
         end
         ST_COOL: begin
            if (!i_Enable) begin
               w_go_down = 1'b1;
            end else if (r_cnt == SETTLE_LAST) begin
               w_supply_nxt[r_idx] = 1'b1;
               w_cnt_nxt           = '0;
               w_state_nxt         = ST_RAMP;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_UP: begin
            // Rails that lose power-good are dropped for good; no retry here.
            w_fault_nxt  = r_fault | (r_supply & ~i_PowerGood);
            w_supply_nxt = w_pre_supply;
            if (!i_Enable) begin
               w_go_down = 1'b1;
            end
         end
         ST_DOWN: begin
            // Enable is ignored here; IDLE looks at it again.
            if (!w_any_on) begin
               w_state_nxt = ST_IDLE;
            end else if (r_cnt == SETTLE_LAST) begin
               w_supply_nxt[w_high_idx] = 1'b0;
               w_cnt_nxt                = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_supply_nxt = '0;
            w_state_nxt  = ST_IDLE;
         end
      endcase

      if (w_advance) begin
         w_retry_nxt = '0;
         w_cnt_nxt   = '0;
         w_good_nxt  = '0;
         if (w_next_found) begin
            w_idx_nxt                = w_next_idx;
            w_supply_nxt[w_next_idx] = 1'b1;
            w_state_nxt              = ST_RAMP;
         end else begin
            w_state_nxt = ST_UP;
         end
      end

      // The highest rail still on drops on the same edge DOWN is entered.
      if (w_go_down) begin
         w_cnt_nxt   = '0;
         w_state_nxt = ST_DOWN;
         if (w_any_on) begin
            w_supply_nxt[w_high_idx] = 1'b0;
         end
      end

      w_ready_nxt = (w_state_nxt == ST_UP) && (|w_supply_nxt);
      w_busy_nxt  = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_UP);
   end

   always_ff @(posedge i_Clock100Mhz) begin
      if (i_Reset) begin
         r_state  <= ST_IDLE;
         r_idx    <= '0;
         r_cnt    <= '0;
         r_good   <= '0;
         r_retry  <= '0;
         r_mask   <= '0;
         r_supply <= '0;
         r_fault  <= '0;
         r_ready  <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_idx    <= w_idx_nxt;
         r_cnt    <= w_cnt_nxt;
         r_good   <= w_good_nxt;
         r_retry  <= w_retry_nxt;
         r_mask   <= w_mask_nxt;
         r_supply <= w_supply_nxt;
         r_fault  <= w_fault_nxt;
         r_ready  <= w_ready_nxt;
         r_busy   <= w_busy_nxt;
      end
   end

   assign o_SupplyOn = r_supply;
   assign o_Fault    = r_fault;
   assign o_Ready    = r_ready;
   assign o_Busy     = r_busy;

endmodule

// File: tb/tb_link_power_sequencer.sv
// Purpose: directed bench for link_power_sequencer with 2 rails, ramp 4, settle 2, one retry.
// Latency: observes outputs 1 time unit after each rising edge; cycle k counts from the edge sampling Enable.
// Backpressure: none; PowerGood is modelled as SupplyOn delayed one cycle, with a per-rail kill override.
module tb_link_power_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [1:0] mask;
   logic [1:0] power_good;
   logic [1:0] supply_on;
   logic [1:0] fault;
   logic       ready;
   logic       busy;

   logic [1:0] pg_lag = 2'b00;
   logic [1:0] pg_kill;
   logic [5:0] obs;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   // Rail comparator model: good one cycle after the rail is enabled.
   always @(posedge clk) pg_lag <= supply_on;
   assign power_good = pg_lag & ~pg_kill;

   // Observed word: {SupplyOn[1:0], Fault[1:0], Ready, Busy}
   assign obs = {supply_on, fault, ready, busy};

   link_power_sequencer #(
      .CHANNELS      (2),
      .RAMP_CYCLES   (4),
      .SETTLE_CYCLES (2),
      .RETRY_LIMIT   (1),
      .COUNT_WIDTH   (8)
   ) dut (
      .i_Clock100Mhz (clk),
      .i_Reset       (rst),
      .i_Enable      (enable),
      .i_ChannelMask (mask),
      .i_PowerGood   (power_good),
      .o_SupplyOn    (supply_on),
      .o_Fault       (fault),
      .o_Ready       (ready),
      .o_Busy        (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b0; mask = 2'b00; pg_kill = 2'b00;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_cmp++;
         if (obs !== 6'b000000) begin
            n_bad++;
            $display("FAIL reset cycle=%0d got=%b want=%b", k, obs, 6'b000000);
         end
      end
      rst = 1'b0;
      tick();
      n_cmp++;
      if (obs !== 6'b000000) begin
         n_bad++;
         $display("FAIL reset_release got=%b want=%b", obs, 6'b000000);
      end
   endtask

   task automatic test_mask_zero();
      enable = 1'b1; mask = 2'b00;
      for (int k = 1; k <= 3; k++) begin
         tick();
         n_cmp++;
         if (obs !== 6'b000000) begin
            n_bad++;
            $display("FAIL mask_zero k=%0d got=%b want=%b", k, obs, 6'b000000);
         end
      end
      enable = 1'b0;
   endtask

   task automatic test_seq_both();
      logic [5:0] exp;
      enable = 1'b1; mask = 2'b11;
      for (int k = 1; k <= 14; k++) begin
         tick();
         exp = {k >= 7, k >= 1, 2'b00, k >= 13, k <= 12};
         n_cmp++;
         if (obs !== exp) begin
            n_bad++;
            $display("FAIL seq_both k=%0d got=%b want=%b", k, obs, exp);
         end
      end
   endtask

   task automatic test_up_fault();
      logic [5:0] exp;
      exp = {2'b01, 2'b10, 1'b1, 1'b0};
      pg_kill = 2'b10;
      tick();
      pg_kill = 2'b00;
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL up_fault_edge got=%b want=%b", obs, exp);
      end
      tick();
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL up_fault_hold got=%b want=%b", obs, exp);
      end
   endtask

   task automatic test_enable_drop();
      logic [5:0] exp;
      logic [5:0] dn [4];
      // Teardown of the remaining rail, then re-sequence with Fault cleared.
      enable = 1'b0;
      tick();
      exp = {2'b00, 2'b10, 1'b0, 1'b1};
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL drop_single_down got=%b want=%b", obs, exp);
      end
      tick();
      exp = {2'b00, 2'b10, 1'b0, 1'b0};
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL drop_single_idle got=%b want=%b", obs, exp);
      end
      enable = 1'b1; mask = 2'b11;
      for (int k = 1; k <= 13; k++) begin
         tick();
         exp = {k >= 7, k >= 1, 2'b00, k >= 13, k <= 12};
         n_cmp++;
         if (obs !== exp) begin
            n_bad++;
            $display("FAIL reseq k=%0d got=%b want=%b", k, obs, exp);
         end
      end
      dn[0] = {2'b01, 2'b00, 1'b0, 1'b1};
      dn[1] = {2'b01, 2'b00, 1'b0, 1'b1};
      dn[2] = {2'b00, 2'b00, 1'b0, 1'b1};
      dn[3] = {2'b00, 2'b00, 1'b0, 1'b0};
      enable = 1'b0;
      for (int d = 0; d < 4; d++) begin
         tick();
         n_cmp++;
         if (obs !== dn[d]) begin
            n_bad++;
            $display("FAIL step_down d=%0d got=%b want=%b", d + 1, obs, dn[d]);
         end
      end
   endtask

   task automatic test_mask_10();
      logic [5:0] exp;
      logic [5:0] dn [5];
      enable = 1'b1; mask = 2'b10;
      for (int k = 1; k <= 8; k++) begin
         tick();
         exp = {k >= 1, 1'b0, 2'b00, k >= 7, k <= 6};
         n_cmp++;
         if (obs !== exp) begin
            n_bad++;
            $display("FAIL mask_10 k=%0d got=%b want=%b", k, obs, exp);
         end
         // A mask change after leaving IDLE must have no effect.
         if (k == 2) mask = 2'b01;
      end
      // Enable re-raised during DOWN: step-down completes, IDLE restarts rail 0.
      dn[0] = {2'b00, 2'b00, 1'b0, 1'b1};
      dn[1] = {2'b00, 2'b00, 1'b0, 1'b0};
      dn[2] = {2'b01, 2'b00, 1'b0, 1'b1};
      dn[3] = {2'b00, 2'b00, 1'b0, 1'b1};
      dn[4] = {2'b00, 2'b00, 1'b0, 1'b0};
      enable = 1'b0;
      for (int d = 0; d < 5; d++) begin
         tick();
         n_cmp++;
         if (obs !== dn[d]) begin
            n_bad++;
            $display("FAIL mask_10_down d=%0d got=%b want=%b", d + 1, obs, dn[d]);
         end
         if (d == 0) enable = 1'b1;
         if (d == 2) enable = 1'b0;
      end
   endtask

   task automatic test_retry();
      logic [5:0] exp;
      logic       s0;
      pg_kill = 2'b01;
      enable = 1'b1; mask = 2'b11;
      for (int k = 1; k <= 26; k++) begin
         tick();
         s0  = (k <= 8) || (k >= 11 && k <= 18);
         exp = {k >= 19, s0, 1'b0, k >= 19, k >= 25, k <= 24};
         n_cmp++;
         if (obs !== exp) begin
            n_bad++;
            $display("FAIL retry k=%0d got=%b want=%b", k, obs, exp);
         end
      end
      enable = 1'b0;
      tick();
      exp = {2'b00, 2'b01, 1'b0, 1'b1};
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL retry_down got=%b want=%b", obs, exp);
      end
      tick();
      exp = {2'b00, 2'b01, 1'b0, 1'b0};
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL retry_idle got=%b want=%b", obs, exp);
      end
      pg_kill = 2'b00;
   endtask

   task automatic test_reset_mid();
      logic [5:0] exp;
      pg_kill = 2'b01;
      enable = 1'b1; mask = 2'b11;
      for (int k = 1; k <= 23; k++) tick();
      // Rail 1 is in SETTLE with rail 0 faulted.
      exp = {2'b10, 2'b01, 1'b0, 1'b1};
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL reset_mid_pre got=%b want=%b", obs, exp);
      end
      rst = 1'b1;
      tick();
      n_cmp++;
      if (obs !== 6'b000000) begin
         n_bad++;
         $display("FAIL reset_mid got=%b want=%b", obs, 6'b000000);
      end
      rst = 1'b0;
      tick();
      exp = {2'b01, 2'b00, 1'b0, 1'b1};
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL reset_mid_restart got=%b want=%b", obs, exp);
      end
      enable = 1'b0;
      pg_kill = 2'b00;
      tick();
      tick();
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; mask = 2'b00; pg_kill = 2'b00;
      test_reset();
      test_mask_zero();
      test_seq_both();
      test_up_fault();
      test_enable_drop();
      test_mask_10();
      test_retry();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/link_power_sequencer.md
# link_power_sequencer

Parametrised multi-channel power sequencer for the link's LNA/split-radio supply rails, replacing single-rail, always-on hookup. Brings up to CHANNELS supply rails on in ascending index order, each with a ramp period, a power-good qualification window and bounded retries. Monitors running rails, latches per-channel faults, and powers down in reverse order. Sits between the link's core clock domain (Clock100Mhz) and the per-rail supply enables feeding the LNA and split-radio stages.

## Interface
- CHANNELS, 4: number of supply rails, 1..16.
- RAMP_CYCLES, 1000: cycles a rail is enabled before power-good is checked; also the settle timeout.
- SETTLE_CYCLES, 100: consecutive power-good cycles required to qualify a rail; also the cool-off and power-down step length.
- RETRY_LIMIT, 3: re-attempts after the first failed attempt, before a rail is declared faulted.
- COUNT_WIDTH, 16: cycle counter width; must hold max(RAMP_CYCLES, SETTLE_CYCLES).

- Clock100Mhz  in  1  single clock; all logic on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- Enable  in  1  level request: 1 = sequence up and hold, 0 = sequence down.
- ChannelMask  in  CHANNELS  1 = rail participates; sampled only on leaving IDLE.
- PowerGood  in  CHANNELS  per-rail comparator status, already synchronous to Clock100Mhz.
- SupplyOn  out  CHANNELS  per-rail supply enable.
- Fault  out  CHANNELS  sticky per-rail fault flag.
- Ready  out  1  sequence complete and at least one rail up.
- Busy  out  1  high in any state other than IDLE and UP.

## Operation
- States: IDLE, RAMP, SETTLE, COOL, UP, DOWN.
- Reset: state IDLE. SupplyOn, Fault, Ready and Busy are 0. Counters and retry count are 0. Reset takes priority in every state; rails drop in the cycle after Reset is sampled, with no reverse-order step-down.
- IDLE: on Enable=1 with ChannelMask≠0:
  - latch the mask; clear Fault;
  - set idx to the lowest masked channel; go to RAMP.
- With Enable=1 and mask=0, stay in IDLE.
- RAMP: SupplyOn[idx]=1. Count RAMP_CYCLES cycles, then go to SETTLE.
- SETTLE: SupplyOn[idx] stays 1.
  - Good-run counter increments on PowerGood[idx]=1 and clears on 0.
  - On reaching SETTLE_CYCLES: the rail qualifies. Advance idx to the next masked channel and go to RAMP, or go to UP if none remain.
  - If RAMP_CYCLES settle cycles elapse unqualified, the attempt fails:
    - retries < RETRY_LIMIT: SupplyOn[idx]=0, retries+1, go to COOL.
    - otherwise: Fault[idx]=1, rail stays off, advance as on success.
  - Retry count clears on each advance.
- COOL: SupplyOn[idx]=0 for SETTLE_CYCLES cycles, then go to RAMP for the same idx.
- UP: Ready=1 iff any SupplyOn bit is 1.
  - Any on rail sampling PowerGood=0 has SupplyOn cleared and Fault set in the next cycle. No auto-retry.
  - Ready falls when the last rail drops.
- Enable=0 in RAMP, SETTLE, COOL or UP: go to DOWN and Ready=0.
- DOWN: clear the highest-index on rail every SETTLE_CYCLES cycles; the first rail clears on DOWN entry. Go to IDLE the cycle after all rails are off. Enable=1 during DOWN does not abort the step-down; IDLE re-evaluates Enable.
- Fault is sticky until Reset or the next IDLE→RAMP transition.

## Timing
- Enable sampled high at edge t (from IDLE): the first masked rail's SupplyOn is 1 from t+1.
- Fault-free rail, exactly RAMP_CYCLES+SETTLE_CYCLES cycles:
  - RAMP_CYCLES cycles in RAMP;
  - SETTLE_CYCLES cycles in SETTLE with PowerGood constantly 1.
- The next rail's SupplyOn rises the cycle after the previous rail qualifies. Rails overlap; qualified rails stay on.
- N masked rails, all good: Ready rises at t+1+N·(RAMP_CYCLES+SETTLE_CYCLES).
- Failed attempt: RAMP_CYCLES+RAMP_CYCLES (settle timeout)+SETTLE_CYCLES (COOL) cycles before re-ramp.
- Faults in UP: one cycle from the PowerGood=0 sample to SupplyOn=0 and Fault=1.
- All outputs are registered.

## Test plan
- CHANNELS=2, R=4, S=2, mask=2'b11, PowerGood follows SupplyOn with 1-cycle lag: SupplyOn[0] at t+1, SupplyOn[1] at t+7, Ready at t+13, Busy 1 over t+1..t+12.
- Same setup with mask=2'b10: rail 0 never enabled; SupplyOn[1] at t+1, Ready at t+7.
- PowerGood[0] held 0, RETRY_LIMIT=1: two ramp attempts separated by a 2-cycle COOL; then Fault[0]=1, SupplyOn[0]=0, and rail 1 sequences normally; Ready=1.
- In UP, pulse PowerGood[1]=0 for one cycle: next cycle SupplyOn[1]=0 and Fault[1]=1; rail 0 stays on; Ready stays 1.
- Drop Enable in UP with both rails on: SupplyOn[1] clears on DOWN entry, SupplyOn[0] clears 2 cycles later, IDLE follows 1 cycle after that; a new Enable clears Fault.
- Assert Reset mid-SETTLE: next cycle all outputs are 0, state is IDLE, and Fault is cleared.
